// File: rtl/wb_write_sequencer.sv
// Writeback sequencer: buffers ALU/load results and issues clock_4 register writes.
// Optional WB_WRITE_STATS_EN adds write and drop counters.
module wb_write_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock_4,
    input  logic          reset,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [2:0]    wb_dest,
    input  logic [31:0]   wb_data,
    input  logic          wb_hold,
    output logic [3:0]    read_or_write,
    output logic [31:0]   write_data,
    output logic          wb_err,
    output logic [AW:0]   fifo_count
`ifdef WB_WRITE_STATS_EN
    ,
    output logic [15:0]   wb_write_cnt,
    output logic [7:0]    wb_err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    localparam logic [AW:0]   FULL  = DEPTH[AW:0];
    localparam logic [AW:0]   C_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] P_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        next_state;
    logic [34:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          non_empty;
    logic [2:0]    head_dest;
    logic [31:0]   head_data;
    logic [3:0]    code_nxt;
    logic          err_nxt;
    logic          load_data;

    assign wb_ready   = (count != FULL);
    assign fifo_count = count;
    assign non_empty  = (count != '0);
    assign push       = wb_valid && wb_ready;
    assign head_dest  = mem[rd_ptr][34:32];
    assign head_data  = mem[rd_ptr][31:0];

    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, ISSUE: begin
                if (wb_hold)        next_state = HOLD;
                else if (non_empty) next_state = ISSUE;
                else                next_state = IDLE;
            end
            HOLD: begin
                if (wb_hold)        next_state = HOLD;
                else if (non_empty) next_state = ISSUE;
                else                next_state = IDLE;
            end
            default:                next_state = IDLE;
        endcase
    end

    // Entering ISSUE pops the head and registers its write in the same edge.
    always_comb begin
        pop       = (next_state == ISSUE);
        code_nxt  = 4'h0;
        err_nxt   = 1'b0;
        load_data = 1'b0;
        if (pop) begin
            load_data = 1'b1;
            case (head_dest)
                3'd0:    code_nxt = 4'h2;
                3'd1:    code_nxt = 4'h3;
                3'd2:    code_nxt = 4'h4;
                3'd3:    code_nxt = 4'h6;
                default: begin
                    err_nxt   = 1'b1;
                    load_data = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_4) begin
        if (push) mem[wr_ptr] <= {wb_dest, wb_data};
    end

    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + P_ONE;
            if (pop)  rd_ptr <= rd_ptr + P_ONE;
            if (push && !pop)      count <= count + C_ONE;
            else if (pop && !push) count <= count - C_ONE;
        end
    end

    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            read_or_write <= 4'h0;
            write_data    <= 32'h0;
            wb_err        <= 1'b0;
        end else begin
            read_or_write <= code_nxt;
            wb_err        <= err_nxt;
            if (load_data) write_data <= head_data;
        end
    end

`ifdef WB_WRITE_STATS_EN
    always_ff @(posedge clock_4 or posedge reset) begin
        if (reset) begin
            wb_write_cnt <= 16'h0;
            wb_err_cnt   <= 8'h0;
        end else begin
            if (code_nxt != 4'h0) wb_write_cnt <= wb_write_cnt + 16'h1;
            if (err_nxt && wb_err_cnt != 8'hFF) wb_err_cnt <= wb_err_cnt + 8'h1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer; covers the stats counters when
// WB_WRITE_STATS_EN is defined.
module tb_wb_write_sequencer;

    logic        clock_4 = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_hold;
    logic [3:0]  read_or_write;
    logic [31:0] write_data;
    logic        wb_err;
    logic [2:0]  fifo_count;
`ifdef WB_WRITE_STATS_EN
    logic [15:0] wb_write_cnt;
    logic [7:0]  wb_err_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    wb_write_sequencer #(.DEPTH(4), .AW(2)) dut (
        .clock_4       (clock_4),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .wb_hold       (wb_hold),
        .read_or_write (read_or_write),
        .write_data    (write_data),
        .wb_err        (wb_err),
        .fifo_count    (fifo_count)
`ifdef WB_WRITE_STATS_EN
        ,
        .wb_write_cnt  (wb_write_cnt),
        .wb_err_cnt    (wb_err_cnt)
`endif
    );

    always #5 clock_4 = ~clock_4;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_4);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        wb_valid = 1'b0;
        wb_dest  = 3'd0;
        wb_data  = 32'h0;
        wb_hold  = 1'b0;
        #3;
        chk("rst_code",  {28'h0, read_or_write}, 32'h0);
        chk("rst_wdata", write_data,             32'h0);
        chk("rst_err",   {31'h0, wb_err},        32'h0);
        chk("rst_count", {29'h0, fifo_count},    32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", {31'h0, wb_ready}, 32'h1);

        // single push to ebx
        wb_valid = 1'b1; wb_dest = 3'd3; wb_data = 32'h0000_1234;
        tick();
        wb_valid = 1'b0;
        chk("t1_count_acc", {29'h0, fifo_count},    32'h1);
        chk("t1_code_acc",  {28'h0, read_or_write}, 32'h0);
        tick();
        chk("t1_code",  {28'h0, read_or_write}, 32'h6);
        chk("t1_wdata", write_data,             32'h0000_1234);
        chk("t1_count", {29'h0, fifo_count},    32'h0);
        tick();
        chk("t1_code_after",  {28'h0, read_or_write}, 32'h0);
        chk("t1_wdata_after", write_data,             32'h0000_1234);

        // fill under hold
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_dest = 3'(i); wb_data = 32'(i + 1);
            tick();
            chk("t2_hold_code", {28'h0, read_or_write}, 32'h0);
        end
        wb_valid = 1'b0;
        chk("t2_count", {29'h0, fifo_count}, 32'h4);
        chk("t2_ready", {31'h0, wb_ready},   32'h0);
        tick();
        chk("t2_still_held", {28'h0, read_or_write}, 32'h0);

        // fifth push held valid across release
        wb_valid = 1'b1; wb_dest = 3'd1; wb_data = 32'h5;
        wb_hold = 1'b0;
        tick();
        chk("t3_code0",  {28'h0, read_or_write}, 32'h2);
        chk("t3_data0",  write_data,             32'h1);
        chk("t3_count0", {29'h0, fifo_count},    32'h3);
        tick();
        wb_valid = 1'b0;
        chk("t3_code1",  {28'h0, read_or_write}, 32'h3);
        chk("t3_data1",  write_data,             32'h2);
        chk("t3_count1", {29'h0, fifo_count},    32'h3);
        tick();
        chk("t3_code2",  {28'h0, read_or_write}, 32'h4);
        chk("t3_data2",  write_data,             32'h3);
        tick();
        chk("t3_code3",  {28'h0, read_or_write}, 32'h6);
        chk("t3_data3",  write_data,             32'h4);
        tick();
        chk("t3_code4",  {28'h0, read_or_write}, 32'h3);
        chk("t3_data4",  write_data,             32'h5);
        chk("t3_count4", {29'h0, fifo_count},    32'h0);
        tick();
        chk("t3_idle", {28'h0, read_or_write}, 32'h0);

        // invalid destination is dropped
        wb_valid = 1'b1; wb_dest = 3'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_valid = 1'b0;
        chk("t4_err_acc", {31'h0, wb_err}, 32'h0);
        tick();
        chk("t4_err",   {31'h0, wb_err},        32'h1);
        chk("t4_code",  {28'h0, read_or_write}, 32'h0);
        chk("t4_wdata", write_data,             32'h5);
        tick();
        chk("t4_err_off", {31'h0, wb_err}, 32'h0);

        // reset during back-to-back issue
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_dest = 3'(i); wb_data = 32'hA0 + 32'(i);
            tick();
        end
        wb_valid = 1'b0;
        wb_hold = 1'b0;
        tick();
        chk("t5_code_pre", {28'h0, read_or_write}, 32'h2);
        chk("t5_data_pre", write_data,             32'hA0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_code_rst",  {28'h0, read_or_write}, 32'h0);
        chk("t5_count_rst", {29'h0, fifo_count},    32'h0);
        chk("t5_wdata_rst", write_data,             32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_code_post",  {28'h0, read_or_write}, 32'h0);
            chk("t5_count_post", {29'h0, fifo_count},    32'h0);
        end

`ifdef WB_WRITE_STATS_EN
        chk("s_wcnt_rst", {16'h0, wb_write_cnt}, 32'h0);
        chk("s_ecnt_rst", {24'h0, wb_err_cnt},   32'h0);
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1;
            wb_dest  = (i == 2) ? 3'd7 : 3'(i);
            wb_data  = 32'(i);
            tick();
        end
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("s_wcnt", {16'h0, wb_write_cnt}, 32'h3);
        chk("s_ecnt", {24'h0, wb_err_cnt},   32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
